bms_adc_monitor: RTL and testbench
==================================

// Module: bms_adc_monitor
// PURPOSE
//  Parametrised ADC front-end for the BMS: N-cell voltage, pack current, temperature.
//  Captures qualified samples, reports pack min/max cell voltage, and raises
//  debounced, latched OV/UV/OC/OT faults with hysteresis-gated clearing.
//  Sits between the ADC sequencer and the protection/contactor controller.
// PARAMETERS
//  NUM_CELLS  3     number of series cells monitored (>=1)
//  ADC_W      12    ADC code width
//  OV_TH      4090  cell over-voltage trip code (trip when code >= OV_TH)
//  UV_TH      2790  cell under-voltage trip code (trip when code <= UV_TH)
//  OC_TH      3072  pack over-current trip code (trip when code >= OC_TH)
//  OT_TH      745   over-temperature trip code (trip when code >= OT_TH)
//  HYST       16    release band in codes; must be < every threshold and < 2^ADC_W-1-UV_TH
//  DEBOUNCE   4     consecutive tripping samples needed to set a fault (>=1)
// PORTS
//  clk               in   1                system clock, rising edge
//  rst               in   1                asynchronous reset, active-high
//  sample_valid      in   1                ADC inputs valid this cycle
//  cell_voltage_adc  in   NUM_CELLS*ADC_W  cell codes, cell i at [i*ADC_W +: ADC_W]
//  pack_current_adc  in   ADC_W            pack current code
//  temperature_adc   in   ADC_W            temperature code
//  fault_clear       in   1                request to release latched faults
//  data_valid        out  1                one-cycle pulse: registered outputs updated
//  cell_voltage_reg  out  NUM_CELLS*ADC_W  last captured cell codes
//  pack_current_reg  out  ADC_W            last captured current code
//  temperature_reg   out  ADC_W            last captured temperature code
//  cell_max          out  ADC_W            max cell code of last sample
//  cell_min          out  ADC_W            min cell code of last sample
//  ov_cell_mask      out  NUM_CELLS        per-cell latched OV
//  uv_cell_mask      out  NUM_CELLS        per-cell latched UV
//  ov_fault, uv_fault, oc_fault, ot_fault  out 1  latched faults (OR of masks for OV/UV)
//  fault_any         out  1                OR of all four faults
// BEHAVIOUR
//  - Reset (async, any time): all outputs and counters 0, cell_min 0; mid-debounce progress lost.
//  - Capture: sample_valid high at edge k -> *_reg, cell_max/min, counters updated at edge k;
//    data_valid high for exactly the cycle after edge k. No valid -> all state holds.
//  - cell_max/cell_min: unsigned compare over all NUM_CELLS; ties irrelevant (value only).
//  - Debounce: one counter per cell for OV, per cell for UV, one each for OC, OT;
//    width $clog2(DEBOUNCE+1). On valid sample: trip -> counter+1, saturating at DEBOUNCE;
//    non-trip -> counter 0. Counter reaching DEBOUNCE sets that fault bit at the same edge.
//    DEBOUNCE=1 -> fault asserts on the capture edge of the first tripping sample.
//  - Latch: fault bits are sticky; a non-tripping sample never clears them.
//  - Release condition (against registered sample): OV cell code < OV_TH-HYST;
//    UV cell code > UV_TH+HYST; OC code < OC_TH-HYST; OT code < OT_TH-HYST.
//  - fault_clear high at an edge: each set fault bit whose release condition holds is
//    cleared and its counter zeroed; bits not meeting release stay set (per cell, per class).
//  - Simultaneous fault_clear and sample_valid: release evaluated on the NEW sample;
//    if the new sample trips that bit, clear is ignored for it and the counter increments.
//  - A cell may hold OV and UV counters independently; both bits never trip on one sample
//    because OV_TH > UV_TH is required (elaboration check; also DEBOUNCE>=1, NUM_CELLS>=1).
//  - fault_any and ov_fault/uv_fault are combinational ORs of the registered bits.
// TESTING
//  T1 reset: rst pulsed mid-run with faults set -> all outputs 0 asynchronously, before next edge.
//  T2 debounce: cell1=4095 for 3 valid samples, then 3000 -> no OV; 4 samples -> ov_fault
//     and ov_cell_mask=3'b010 set on 4th capture edge, data_valid pulses each sample.
//  T3 hysteresis: after OV on cell0, sample 4080 + fault_clear -> stays set; 4070 +
//     fault_clear -> cleared next edge, counter 0 (4 more trips needed to re-set).
//  T4 min/max & UV: cells {3000,2700,3500} x4 samples -> cell_min=2700, cell_max=3500,
//     uv_cell_mask=3'b010 after 4th; OC at 3072 and OT at 745 set after 4 samples each.
//  T5 simultaneous: OT latched, fault_clear with valid sample temp=800 -> OT stays set;
//     gaps in sample_valid between trips do not reset counters.
//  T6 params: NUM_CELLS=8, ADC_W=16, DEBOUNCE=1 -> single tripping sample on cell 7 sets
//     ov_cell_mask[7] on its capture edge.

Source files
------------

// File: rtl/bms_adc_monitor.sv
// BMS ADC front-end: captures qualified cell/current/temperature samples, tracks cell
// min/max and raises debounced, latched OV/UV/OC/OT faults released with hysteresis.
module bms_adc_monitor #(
  parameter int NUM_CELLS = 3,
  parameter int ADC_W     = 12,
  parameter int OV_TH     = 4090,
  parameter int UV_TH     = 2790,
  parameter int OC_TH     = 3072,
  parameter int OT_TH     = 745,
  parameter int HYST      = 16,
  parameter int DEBOUNCE  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [NUM_CELLS*ADC_W-1:0] cell_voltage_adc,
  input  logic [ADC_W-1:0]           pack_current_adc,
  input  logic [ADC_W-1:0]           temperature_adc,
  input  logic                       fault_clear,
  output logic                       data_valid,
  output logic [NUM_CELLS*ADC_W-1:0] cell_voltage_reg,
  output logic [ADC_W-1:0]           pack_current_reg,
  output logic [ADC_W-1:0]           temperature_reg,
  output logic [ADC_W-1:0]           cell_max,
  output logic [ADC_W-1:0]           cell_min,
  output logic [NUM_CELLS-1:0]       ov_cell_mask,
  output logic [NUM_CELLS-1:0]       uv_cell_mask,
  output logic                       ov_fault,
  output logic                       uv_fault,
  output logic                       oc_fault,
  output logic                       ot_fault,
  output logic                       fault_any
);

  // Detector slots: [0,N) cell OV, [N,2N) cell UV, then pack OC and OT.
  localparam int NUM_DET = 2 * NUM_CELLS + 2;
  localparam int OC_IDX  = 2 * NUM_CELLS;
  localparam int OT_IDX  = 2 * NUM_CELLS + 1;
  localparam int CNT_W   = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [ADC_W-1:0] OV_TH_C  = ADC_W'(OV_TH);
  localparam logic [ADC_W-1:0] UV_TH_C  = ADC_W'(UV_TH);
  localparam logic [ADC_W-1:0] OC_TH_C  = ADC_W'(OC_TH);
  localparam logic [ADC_W-1:0] OT_TH_C  = ADC_W'(OT_TH);
  localparam logic [ADC_W-1:0] OV_REL_C = ADC_W'(OV_TH - HYST);
  localparam logic [ADC_W-1:0] UV_REL_C = ADC_W'(UV_TH + HYST);
  localparam logic [ADC_W-1:0] OC_REL_C = ADC_W'(OC_TH - HYST);
  localparam logic [ADC_W-1:0] OT_REL_C = ADC_W'(OT_TH - HYST);

  if (NUM_CELLS < 1 || DEBOUNCE < 1 || OV_TH <= UV_TH) begin : g_bad_params
    $error("bms_adc_monitor: need NUM_CELLS>=1, DEBOUNCE>=1 and OV_TH>UV_TH");
  end

  logic                       data_valid_r;
  logic [NUM_CELLS*ADC_W-1:0] cell_reg_r;
  logic [ADC_W-1:0]           cur_reg_r;
  logic [ADC_W-1:0]           temp_reg_r;
  logic [ADC_W-1:0]           max_r;
  logic [ADC_W-1:0]           min_r;
  logic [NUM_DET-1:0]         flt_r;
  logic [CNT_W-1:0]           cnt_r [NUM_DET];

  logic [NUM_CELLS*ADC_W-1:0] src_cells_s;
  logic [ADC_W-1:0]           src_cur_s;
  logic [ADC_W-1:0]           src_temp_s;
  logic [ADC_W-1:0]           max_s;
  logic [ADC_W-1:0]           min_s;
  logic [NUM_DET-1:0]         trip_s;
  logic [NUM_DET-1:0]         rel_s;
  logic [NUM_DET-1:0]         clr_s;
  logic [NUM_DET-1:0]         flt_nxt_s;
  logic [CNT_W-1:0]           cnt_nxt_s [NUM_DET];

  // Release is judged on the incoming sample when one arrives, else on the held one.
  always_comb begin
    if (sample_valid) begin
      src_cells_s = cell_voltage_adc;
      src_cur_s   = pack_current_adc;
      src_temp_s  = temperature_adc;
    end else begin
      src_cells_s = cell_reg_r;
      src_cur_s   = cur_reg_r;
      src_temp_s  = temp_reg_r;
    end
  end

  // Per-detector trip (incoming sample) and release (hysteresis band) flags.
  always_comb begin
    trip_s = '0;
    rel_s  = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      trip_s[i]             = cell_voltage_adc[i*ADC_W +: ADC_W] >= OV_TH_C;
      trip_s[NUM_CELLS + i] = cell_voltage_adc[i*ADC_W +: ADC_W] <= UV_TH_C;
      rel_s[i]              = src_cells_s[i*ADC_W +: ADC_W] < OV_REL_C;
      rel_s[NUM_CELLS + i]  = src_cells_s[i*ADC_W +: ADC_W] > UV_REL_C;
    end
    trip_s[OC_IDX] = pack_current_adc >= OC_TH_C;
    trip_s[OT_IDX] = temperature_adc >= OT_TH_C;
    rel_s[OC_IDX]  = src_cur_s < OC_REL_C;
    rel_s[OT_IDX]  = src_temp_s < OT_REL_C;
  end

  // Unsigned min/max over the incoming cell codes.
  always_comb begin
    max_s = cell_voltage_adc[ADC_W-1:0];
    min_s = cell_voltage_adc[ADC_W-1:0];
    for (int i = 1; i < NUM_CELLS; i++) begin
      if (cell_voltage_adc[i*ADC_W +: ADC_W] > max_s) begin
        max_s = cell_voltage_adc[i*ADC_W +: ADC_W];
      end else begin
        max_s = max_s;
      end
      if (cell_voltage_adc[i*ADC_W +: ADC_W] < min_s) begin
        min_s = cell_voltage_adc[i*ADC_W +: ADC_W];
      end else begin
        min_s = min_s;
      end
    end
  end

  assign clr_s = {NUM_DET{fault_clear}} & flt_r & rel_s;

  // Debounce counters and sticky fault bits. A released bit can never also be tripping.
  always_comb begin
    flt_nxt_s = flt_r;
    for (int j = 0; j < NUM_DET; j++) begin
      cnt_nxt_s[j] = cnt_r[j];
      if (clr_s[j]) begin
        cnt_nxt_s[j] = '0;
        flt_nxt_s[j] = 1'b0;
      end else if (sample_valid && trip_s[j]) begin
        if (cnt_r[j] == DEB_C) begin
          cnt_nxt_s[j] = cnt_r[j];
        end else begin
          cnt_nxt_s[j] = cnt_r[j] + ONE_C;
        end
        flt_nxt_s[j] = flt_r[j] | (cnt_nxt_s[j] == DEB_C);
      end else if (sample_valid) begin
        cnt_nxt_s[j] = '0;
        flt_nxt_s[j] = flt_r[j];
      end else begin
        cnt_nxt_s[j] = cnt_r[j];
        flt_nxt_s[j] = flt_r[j];
      end
    end
  end

  // Sample capture, statistics and fault state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid_r <= 1'b0;
      cell_reg_r   <= '0;
      cur_reg_r    <= '0;
      temp_reg_r   <= '0;
      max_r        <= '0;
      min_r        <= '0;
      flt_r        <= '0;
      for (int j = 0; j < NUM_DET; j++) begin
        cnt_r[j] <= '0;
      end
    end else begin
      data_valid_r <= sample_valid;
      if (sample_valid) begin
        cell_reg_r <= cell_voltage_adc;
        cur_reg_r  <= pack_current_adc;
        temp_reg_r <= temperature_adc;
        max_r      <= max_s;
        min_r      <= min_s;
      end
      flt_r <= flt_nxt_s;
      for (int j = 0; j < NUM_DET; j++) begin
        cnt_r[j] <= cnt_nxt_s[j];
      end
    end
  end

  assign data_valid       = data_valid_r;
  assign cell_voltage_reg = cell_reg_r;
  assign pack_current_reg = cur_reg_r;
  assign temperature_reg  = temp_reg_r;
  assign cell_max         = max_r;
  assign cell_min         = min_r;
  assign ov_cell_mask     = flt_r[NUM_CELLS-1:0];
  assign uv_cell_mask     = flt_r[2*NUM_CELLS-1:NUM_CELLS];
  assign oc_fault         = flt_r[OC_IDX];
  assign ot_fault         = flt_r[OT_IDX];
  assign ov_fault         = |ov_cell_mask;
  assign uv_fault         = |uv_cell_mask;
  assign fault_any        = |flt_r;

endmodule

// File: tb/tb_bms_adc_monitor.sv
// Self-checking bench for bms_adc_monitor: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_bms_adc_monitor;
  localparam int N = 3, W = 12, OV = 4090, UV = 2790, OC = 3072, OT = 745, HY = 16, DEB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             sample_valid, fault_clear;
  logic [N*W-1:0]   cell_voltage_adc;
  logic [W-1:0]     pack_current_adc, temperature_adc;
  logic             data_valid, ov_fault, uv_fault, oc_fault, ot_fault, fault_any;
  logic [N*W-1:0]   cell_voltage_reg;
  logic [W-1:0]     pack_current_reg, temperature_reg, cell_max, cell_min;
  logic [N-1:0]     ov_cell_mask, uv_cell_mask;

  bms_adc_monitor dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .cell_voltage_adc(cell_voltage_adc), .pack_current_adc(pack_current_adc),
    .temperature_adc(temperature_adc), .fault_clear(fault_clear),
    .data_valid(data_valid), .cell_voltage_reg(cell_voltage_reg),
    .pack_current_reg(pack_current_reg), .temperature_reg(temperature_reg),
    .cell_max(cell_max), .cell_min(cell_min), .ov_cell_mask(ov_cell_mask),
    .uv_cell_mask(uv_cell_mask), .ov_fault(ov_fault), .uv_fault(uv_fault),
    .oc_fault(oc_fault), .ot_fault(ot_fault), .fault_any(fault_any)
  );

  // Wide, single-sample-debounce variant.
  logic            s6_valid, s6_clr;
  logic [127:0]    s6_cells;
  logic [15:0]     s6_cur, s6_temp;
  logic            s6_dv, s6_ovf, s6_uvf, s6_ocf, s6_otf, s6_any;
  logic [127:0]    s6_cells_reg;
  logic [15:0]     s6_cur_reg, s6_temp_reg, s6_max, s6_min;
  logic [7:0]      s6_ovm, s6_uvm;

  bms_adc_monitor #(.NUM_CELLS(8), .ADC_W(16), .DEBOUNCE(1)) dut6 (
    .clk(clk), .rst(rst), .sample_valid(s6_valid),
    .cell_voltage_adc(s6_cells), .pack_current_adc(s6_cur),
    .temperature_adc(s6_temp), .fault_clear(s6_clr),
    .data_valid(s6_dv), .cell_voltage_reg(s6_cells_reg),
    .pack_current_reg(s6_cur_reg), .temperature_reg(s6_temp_reg),
    .cell_max(s6_max), .cell_min(s6_min), .ov_cell_mask(s6_ovm),
    .uv_cell_mask(s6_uvm), .ov_fault(s6_ovf), .uv_fault(s6_uvf),
    .oc_fault(s6_ocf), .ot_fault(s6_otf), .fault_any(s6_any)
  );

  int n_cmp = 0, n_err = 0;

  // Reference model state (plain integers).
  int m_cell [N];
  int m_cur, m_temp, m_max, m_min;
  int m_ovc [N];
  int m_uvc [N];
  int m_occ, m_otc;
  bit m_ov [N];
  bit m_uv [N];
  bit m_oc, m_ot, m_dv;

  // Current stimulus, read by the model.
  bit d_valid, d_clr;
  int d_cell [N];
  int d_cur, d_temp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cell[i] = 0; m_ovc[i] = 0; m_uvc[i] = 0; m_ov[i] = 0; m_uv[i] = 0;
    end
    m_cur = 0; m_temp = 0; m_max = 0; m_min = 0;
    m_occ = 0; m_otc = 0; m_oc = 0; m_ot = 0; m_dv = 0;
  endtask

  function automatic int bump(input int c);
    return (c < DEB) ? c + 1 : DEB;
  endfunction

  task automatic model_edge();
    int sc [N];
    int scur, stmp;
    for (int i = 0; i < N; i++) sc[i] = d_valid ? d_cell[i] : m_cell[i];
    scur = d_valid ? d_cur : m_cur;
    stmp = d_valid ? d_temp : m_temp;
    if (d_valid) begin
      for (int i = 0; i < N; i++) begin
        if (d_cell[i] >= OV) begin m_ovc[i] = bump(m_ovc[i]); if (m_ovc[i] == DEB) m_ov[i] = 1; end
        else m_ovc[i] = 0;
        if (d_cell[i] <= UV) begin m_uvc[i] = bump(m_uvc[i]); if (m_uvc[i] == DEB) m_uv[i] = 1; end
        else m_uvc[i] = 0;
      end
      if (d_cur >= OC) begin m_occ = bump(m_occ); if (m_occ == DEB) m_oc = 1; end else m_occ = 0;
      if (d_temp >= OT) begin m_otc = bump(m_otc); if (m_otc == DEB) m_ot = 1; end else m_otc = 0;
    end
    if (d_clr) begin
      for (int i = 0; i < N; i++) begin
        if (m_ov[i] && sc[i] < OV - HY) begin m_ov[i] = 0; m_ovc[i] = 0; end
        if (m_uv[i] && sc[i] > UV + HY) begin m_uv[i] = 0; m_uvc[i] = 0; end
      end
      if (m_oc && scur < OC - HY) begin m_oc = 0; m_occ = 0; end
      if (m_ot && stmp < OT - HY) begin m_ot = 0; m_otc = 0; end
    end
    if (d_valid) begin
      m_max = d_cell[0]; m_min = d_cell[0];
      for (int i = 0; i < N; i++) begin
        m_cell[i] = d_cell[i];
        if (d_cell[i] > m_max) m_max = d_cell[i];
        if (d_cell[i] < m_min) m_min = d_cell[i];
      end
      m_cur = d_cur; m_temp = d_temp;
    end
    m_dv = d_valid;
  endtask

  task automatic check_all();
    logic [N*W-1:0] ec;
    logic [N-1:0]   eov, euv;
    for (int i = 0; i < N; i++) begin
      ec[i*W +: W] = W'(m_cell[i]);
      eov[i] = m_ov[i];
      euv[i] = m_uv[i];
    end
    chk("data_valid", 64'(data_valid), 64'(m_dv));
    chk("cell_reg", 64'(cell_voltage_reg), 64'(ec));
    chk("cur_reg", 64'(pack_current_reg), 64'(m_cur));
    chk("temp_reg", 64'(temperature_reg), 64'(m_temp));
    chk("cell_max", 64'(cell_max), 64'(m_max));
    chk("cell_min", 64'(cell_min), 64'(m_min));
    chk("ov_mask", 64'(ov_cell_mask), 64'(eov));
    chk("uv_mask", 64'(uv_cell_mask), 64'(euv));
    chk("oc_fault", 64'(oc_fault), 64'(m_oc));
    chk("ot_fault", 64'(ot_fault), 64'(m_ot));
    chk("ov_fault", 64'(ov_fault), 64'(|eov));
    chk("uv_fault", 64'(uv_fault), 64'(|euv));
    chk("fault_any", 64'(fault_any), 64'((|eov) | (|euv) | m_oc | m_ot));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next fall.
  task automatic cyc(input bit v, input int c0, input int c1, input int c2,
                     input int cur, input int tmp, input bit clr);
    d_valid = v; d_clr = clr; d_cell[0] = c0; d_cell[1] = c1; d_cell[2] = c2;
    d_cur = cur; d_temp = tmp;
    sample_valid = v; fault_clear = clr;
    cell_voltage_adc = {W'(c2), W'(c1), W'(c0)};
    pack_current_adc = W'(cur);
    temperature_adc = W'(tmp);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  function automatic int pick(input int lo, input int hi);
    if ($urandom_range(3, 0) == 0) return int'($urandom_range(4095, 0));
    return int'($urandom_range(hi, lo));
  endfunction

  int rv [N+2];

  initial begin
    rst = 1'b1; sample_valid = 1'b0; fault_clear = 1'b0;
    cell_voltage_adc = '0; pack_current_adc = '0; temperature_adc = '0;
    s6_valid = 1'b0; s6_clr = 1'b0; s6_cells = '0; s6_cur = '0; s6_temp = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Debounce on cell 1.
    repeat (3) cyc(1, 3000, 4095, 3000, 0, 0, 0);
    chk("t2_no_ov_3", 64'(ov_cell_mask), 64'(0));
    cyc(1, 3000, 3000, 3000, 0, 0, 0);
    repeat (3) cyc(1, 3000, 4095, 3000, 0, 0, 0);
    chk("t2_no_ov_restart", 64'(ov_cell_mask), 64'(0));
    cyc(1, 3000, 4095, 3000, 0, 0, 0);
    chk("t2_ov_mask", 64'(ov_cell_mask), 64'(3'b010));
    chk("t2_dv", 64'(data_valid), 64'(1));

    // Hysteresis on cell 0.
    repeat (4) cyc(1, 4095, 3000, 3000, 0, 0, 0);
    cyc(1, 4080, 3000, 3000, 0, 0, 1);
    chk("t3_hold_4080", 64'(ov_cell_mask), 64'(3'b001));
    cyc(1, 4070, 3000, 3000, 0, 0, 1);
    chk("t3_clear_4070", 64'(ov_cell_mask), 64'(0));
    repeat (3) cyc(1, 4095, 3000, 3000, 0, 0, 0);
    chk("t3_rearm_3", 64'(ov_cell_mask), 64'(0));
    cyc(1, 4095, 3000, 3000, 0, 0, 0);
    chk("t3_rearm_4", 64'(ov_cell_mask), 64'(3'b001));
    cyc(1, 3000, 3000, 3000, 0, 0, 1);

    // Min/max, UV, OC and OT at their exact thresholds.
    repeat (3) cyc(1, 3000, 2700, 3500, 3072, 745, 0);
    chk("t4_uv_3", 64'(uv_cell_mask), 64'(0));
    chk("t4_oc_3", 64'(oc_fault), 64'(0));
    cyc(1, 3000, 2700, 3500, 3072, 745, 0);
    chk("t4_min", 64'(cell_min), 64'(2700));
    chk("t4_max", 64'(cell_max), 64'(3500));
    chk("t4_uv_4", 64'(uv_cell_mask), 64'(3'b010));
    chk("t4_oc_4", 64'(oc_fault), 64'(1));
    chk("t4_ot_4", 64'(ot_fault), 64'(1));

    // Clear together with a tripping sample, then gapped trips.
    cyc(1, 3000, 2700, 3500, 3072, 800, 1);
    chk("t5_ot_kept", 64'(ot_fault), 64'(1));
    cyc(1, 3000, 3000, 3500, 0, 800, 1);
    chk("t5_oc_clr", 64'(oc_fault), 64'(0));
    chk("t5_ot_kept2", 64'(ot_fault), 64'(1));
    cyc(1, 3000, 3000, 3500, 3072, 800, 0);
    cyc(0, 3000, 3000, 3500, 0, 0, 0);
    cyc(1, 3000, 3000, 3500, 3072, 800, 0);
    cyc(0, 3000, 3000, 3500, 0, 0, 0);
    cyc(1, 3000, 3000, 3500, 3072, 800, 0);
    chk("t5_oc_gap_3", 64'(oc_fault), 64'(0));
    cyc(1, 3000, 3000, 3500, 3072, 800, 0);
    chk("t5_oc_gap_4", 64'(oc_fault), 64'(1));

    // Asynchronous reset mid-debounce with faults latched.
    repeat (3) cyc(1, 4095, 3000, 3500, 3072, 800, 0);
    chk("t1_any_before", 64'(fault_any), 64'(1));
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 4095, 3000, 3000, 0, 0, 0);
    chk("t1_progress_lost", 64'(ov_cell_mask), 64'(0));
    repeat (3) cyc(1, 4095, 3000, 3000, 0, 0, 0);
    cyc(1, 3000, 3000, 3000, 0, 0, 1);

    // Wide instance: one tripping sample on cell 7.
    s6_cells = {16'd4095, {7{16'd3000}}};
    s6_valid = 1'b1;
    chk("t6_pre", 64'(s6_ovm), 64'(0));
    @(posedge clk);
    #1;
    chk("t6_ovm", 64'(s6_ovm), 64'(8'h80));
    chk("t6_dv", 64'(s6_dv), 64'(1));
    chk("t6_max", 64'(s6_max), 64'(4095));
    chk("t6_min", 64'(s6_min), 64'(3000));
    @(negedge clk);
    s6_valid = 1'b0;

    // Randomized traffic with slowly changing channel values.
    for (int i = 0; i < N + 2; i++) rv[i] = 3000;
    rv[N] = 0; rv[N+1] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3, 0) == 0) begin
          case ($urandom_range(2, 0))
            0:       rv[i] = pick(4060, 4095);
            1:       rv[i] = pick(2760, 2820);
            default: rv[i] = pick(2800, 4000);
          endcase
        end
      end
      if ($urandom_range(3, 0) == 0) rv[N] = pick(3040, 3100);
      if ($urandom_range(3, 0) == 0) rv[N+1] = pick(715, 775);
      cyc($urandom_range(3, 0) != 0, rv[0], rv[1], rv[2], rv[N], rv[N+1],
          $urandom_range(6, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
